fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 98 +++++++++
 tb/tb_fetch_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// fetch_stage: IF stage, 2-cycle fetch latency, one-entry skid buffer for ID stalls.
// Optional macro FETCH_MISALIGN_TRAP_EN traps misaligned redirects. Rev 1.0
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        fetch_err
);

  logic [31:0] fetch_pc;
  logic [31:0] rsp_pc;
  logic        rsp_valid;
  logic        skid_valid;
  logic [31:0] skid_pc;
  logic [31:0] skid_inst;
  logic        halted;
  logic [31:0] target;
  logic        misalign;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target   = redirect_pc;
  assign misalign = |redirect_pc[1:0];
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign target   = {redirect_pc[31:2], 2'b00};
  assign misalign = 1'b0;
`endif

  // A full skid buffer blocks issue, so at most one response is ever unconsumed.
  assign imem_en   = !stall && !skid_valid && !redirect_valid && !halted;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      rsp_valid  <= 1'b0;
      rsp_pc     <= 32'd0;
      skid_valid <= 1'b0;
      skid_pc    <= 32'd0;
      skid_inst  <= NOP_INST;
      pc         <= 32'd0;
      inst       <= NOP_INST;
      inst_valid <= 1'b0;
      fetch_err  <= 1'b0;
      halted     <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc   <= target;
      rsp_valid  <= 1'b0;
      skid_valid <= 1'b0;
      inst       <= NOP_INST;
      inst_valid <= 1'b0;
      if (misalign) begin
        fetch_err <= 1'b1;
        halted    <= 1'b1;
      end
    end else begin
      rsp_valid <= imem_en;
      if (imem_en) begin
        rsp_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (!stall) begin
        if (skid_valid) begin
          pc         <= skid_pc;
          inst       <= skid_inst;
          inst_valid <= 1'b1;
          skid_valid <= 1'b0;
        end else if (rsp_valid) begin
          pc         <= rsp_pc;
          inst       <= imem_rdata;
          inst_valid <= 1'b1;
        end else begin
          inst       <= NOP_INST;
          inst_valid <= 1'b0;
        end
      end else if (rsp_valid) begin
        skid_valid <= 1'b1;
        skid_pc    <= rsp_pc;
        skid_inst  <= imem_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// tb_fetch_stage: directed scenarios plus random stall/redirect traffic checked
// against an instruction-stream model (consecutive PCs, flush on redirect, hold on stall).
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] pc, inst;
  logic        inst_valid, fetch_err;

  logic        stall2 = 1'b0;
  logic        redirect_valid2 = 1'b0;
  logic [31:0] redirect_pc2 = 32'd0;
  logic        imem_en2;
  logic [31:0] imem_addr2;
  logic [31:0] imem_rdata2 = 32'd0;
  logic [31:0] pc2, inst2;
  logic        inst_valid2, fetch_err2;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc(pc), .inst(inst), .inst_valid(inst_valid), .fetch_err(fetch_err)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset), .stall(stall2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .imem_en(imem_en2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .pc(pc2), .inst(inst2), .inst_valid(inst_valid2), .fetch_err(fetch_err2)
  );

  // Synchronous ROM: word at byte address a is a >> 2.
  always @(posedge clk) if (imem_en)  imem_rdata  <= imem_addr >> 2;
  always @(posedge clk) if (imem_en2) imem_rdata2 <= imem_addr2 >> 2;

  int total = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] p);
    chk1({tag, ".valid"}, inst_valid, v);
    if (v) begin
      chk({tag, ".pc"}, pc, p);
      chk({tag, ".inst"}, inst, p >> 2);
    end else begin
      chk({tag, ".inst"}, inst, NOP);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          idle;
    logic [31:0] exp_pc, ppc, pinst, rp, w;
    logic        pv, rs, rv;

    // Reset state
    repeat (3) tick();
    chk_out("rst", 1'b0, 32'd0);
    chk("rst.pc", pc, 32'd0);
    chk("rst.addr", imem_addr, 32'd0);
    chk1("rst.err", fetch_err, 1'b0);
    chk("rst_wrap.addr", imem_addr2, 32'hFFFF_FFF8);

    // Free-running stream; second instance wraps past the top of memory
    reset = 1'b0;
    tick();
    chk_out("seq.c1", 1'b0, 32'd0);
    chk1("wrap.c1", inst_valid2, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_out("seq", 1'b1, 32'(k * 4));
      if (k < 4) begin
        w = 32'hFFFF_FFF8 + 32'(k * 4);
        chk1("wrap.valid", inst_valid2, 1'b1);
        chk("wrap.pc", pc2, w);
        chk("wrap.inst", inst2, w >> 2);
      end
    end
    chk1("wrap.err", fetch_err2, 1'b0);

    // Three-cycle stall at pc=0x10
    stall = 1'b1;
    #1 chk1("stall.en", imem_en, 1'b0);
    repeat (3) begin
      tick();
      chk_out("stall.hold", 1'b1, 32'h10);
    end
    stall = 1'b0;
    tick(); chk_out("stall.skid", 1'b1, 32'h14);
    tick(); chk_out("stall.bubble", 1'b0, 32'd0);
    tick(); chk_out("stall.next", 1'b1, 32'h18);

    // Redirect during stall
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick(); chk_out("redir.flush", 1'b0, 32'd0);
    stall = 1'b0; redirect_valid = 1'b0;
    tick(); chk_out("redir.bubble", 1'b0, 32'd0);
    tick(); chk_out("redir.tgt", 1'b1, 32'h100);
    tick(); chk_out("redir.tgt4", 1'b1, 32'h104);

    // Random traffic against the stream model
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_pc = 32'd0;
    idle = 0;
    for (int n = 0; n < 400; n++) begin
      rs = ($urandom_range(0, 9) < 3);
      rv = ($urandom_range(0, 9) == 0);
      rp = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);
      stall = rs; redirect_valid = rv; redirect_pc = rp;
      ppc = pc; pinst = inst; pv = inst_valid;
      tick();
      if (rv) begin
        chk_out("rnd.flush", 1'b0, 32'd0);
        exp_pc = rp;
        idle = 0;
      end else if (rs) begin
        chk1("rnd.hold.valid", inst_valid, pv);
        chk("rnd.hold.pc", pc, ppc);
        chk("rnd.hold.inst", inst, pinst);
        idle = 0;
      end else if (inst_valid) begin
        chk("rnd.pc", pc, exp_pc);
        chk("rnd.inst", inst, exp_pc >> 2);
        exp_pc = exp_pc + 32'd4;
        idle = 0;
      end else begin
        idle++;
        chk("rnd.bubble.inst", inst, NOP);
        chk1("rnd.gap_le1", idle > 1, 1'b0);
      end
    end
    stall = 1'b0; redirect_valid = 1'b0;

    // Reset with skid full; stall and redirect asserted alongside reset
    repeat (3) tick();
    stall = 1'b1;
    tick();
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    chk_out("rst2", 1'b0, 32'd0);
    chk("rst2.pc", pc, 32'd0);
    chk("rst2.addr", imem_addr, 32'd0);
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    #1 chk1("rst2.en", imem_en, 1'b1);
    tick(); chk_out("rst2.c1", 1'b0, 32'd0);
    tick(); chk_out("rst2.c2", 1'b1, 32'd0);
    tick(); chk_out("rst2.c3", 1'b1, 32'd4);

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick(); chk_out("mis.flush", 1'b0, 32'd0);
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk1("mis.err", fetch_err, 1'b1);
    repeat (4) begin
      #1 chk1("mis.en", imem_en, 1'b0);
      tick();
      chk1("mis.valid", inst_valid, 1'b0);
    end
    chk1("mis.err_sticky", fetch_err, 1'b1);
`else
    chk1("mis.err", fetch_err, 1'b0);
    tick(); chk_out("mis.bubble", 1'b0, 32'd0);
    tick(); chk_out("mis.tgt", 1'b1, 32'h100);
    tick(); chk_out("mis.tgt4", 1'b1, 32'h104);
`endif
    reset = 1'b1;
    tick();
    chk1("fin.err", fetch_err, 1'b0);
    reset = 1'b0;
    #1 chk1("fin.en", imem_en, 1'b1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
`default_nettype wire
